imem_loader: RTL and testbench

- Writer side of the instruction memory.
- Accepts a byte stream (valid/ready) from a host or boot link and packs it little-endian into 32-bit words.
- Writes the words sequentially into the instruction memory write port, starting at word 0.
- Holds the pipelined core in reset/stall via cpu_hold until the program is fully loaded.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and sizing helpers for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  localparam int unsigned DEPTH = depth_of(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles four accepted stream bytes into one little-endian word.
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_full_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      // Counter wraps to 0 on the fourth byte, ready for the next word.
      cnt_d = cnt_q + 2'd1;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (cnt_q == 2'(k)) word_d[8*k +: 8] = byte_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = accept_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory word by word and keeps the core
// held until the program image is completely written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  cpu_hold
);

  localparam int unsigned         MEM_DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W     = (ADDR_WIDTH+1)'(1);

  // Byte handshake: a byte moves on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready depends only on state.
  state_e state_q, state_d;

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] word_index_q, word_index_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  err_q, err_d;
  logic [31:0]           addr_hold_q, addr_hold_d;
  logic [DATA_WIDTH-1:0] wdata_hold_q, wdata_hold_d;

  logic                  start_ok;
  logic                  accept;
  logic                  last_word;
  logic [31:0]           cur_addr;
  logic [DATA_WIDTH-1:0] pk_word;
  logic                  pk_full;

  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept    = byte_valid && byte_ready;
  assign last_word = (({1'b0, word_index_q} + ONE_W) == count_q);
  assign cur_addr  = {{(30-ADDR_WIDTH){1'b0}}, word_index_q, 2'b00};

  imem_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (start_ok),
    .accept_i    (accept),
    .byte_i      (byte_data),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if ((word_count == '0) || (word_count > DEPTH_W)) state_d = ST_DONE;
          else                                              state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: if (pk_full) state_d = ST_WRITE;
      ST_WRITE:   state_d = last_word ? ST_DONE : ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == ST_COLLECT);
    mem_we     = (state_q == ST_WRITE);
    busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
    // An oversize request ends in DONE but must not release the core.
    cpu_hold   = !((state_q == ST_DONE) && !err_q);
    mem_addr   = mem_we ? cur_addr : addr_hold_q;
    mem_wdata  = mem_we ? pk_word  : wdata_hold_q;
    checksum   = checksum_q;
    err        = err_q;
  end

  always_comb begin
    count_d      = count_q;
    word_index_d = word_index_q;
    checksum_d   = checksum_q;
    err_d        = err_q;
    addr_hold_d  = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    if (start_ok) begin
      count_d      = word_count;
      word_index_d = '0;
      checksum_d   = '0;
      err_d        = (word_count > DEPTH_W);
    end else if (state_q == ST_WRITE) begin
      checksum_d   = checksum_q ^ pk_word;
      addr_hold_d  = cur_addr;
      wdata_hold_d = pk_word;
      if (!last_word) word_index_d = word_index_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      word_index_q <= '0;
      checksum_q   <= '0;
      err_q        <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      count_q      <= count_d;
      word_index_q <= word_index_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized byte-stream loads of imem_loader against a
// little-endian packing model of the expected memory image.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   checksum;
  logic          cpu_hold;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum),
    .cpu_hold   (cpu_hold)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          we_count = 0;
  logic        ready_stall_ok;
  logic [7:0]  stream_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr_q.push_back(mem_addr);
      got_data_q.push_back(mem_wdata);
      we_count++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    got_addr_q.delete();
    got_data_q.delete();
    we_count = 0;
    ready_stall_ok = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_mem_addr"},   mem_addr,        32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
    chk({tag, "_checksum"},   checksum,        32'd0);
    chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input int cnt);
    start = 1'b1;
    word_count = (AW+1)'(cnt);
    tick();
    start = 1'b0;
  endtask

  task automatic random_stream(input int nbytes);
    stream_q.delete();
    for (int i = 0; i < nbytes; i++) stream_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Offer stream bytes [lo, hi) with a random idle gap after each byte.
  task automatic send_range(input int lo, input int hi, input int gmin, input int gmax);
    for (int i = lo; i < hi; i++) begin
      int guard;
      int gap;
      byte_valid = 1'b1;
      byte_data  = stream_q[i];
      guard = 0;
      while (byte_ready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) chk($sformatf("byte_ready_wait_%0d", i), 32'(byte_ready), 32'd1);
      tick();
      byte_valid = 1'b0;
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) begin
        if ((i % 4) != 3 && byte_ready !== 1'b1) ready_stall_ok = 1'b0;
        tick();
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Reference: byte 4i+b lands at weight 256**b of word i, word i at byte
  // address 4i, checksum is the XOR of all whole words.
  task automatic check_load(input string tag, input int nwords);
    logic [31:0] sum;
    int          n;
    exp_q.delete();
    sum = 32'd0;
    for (int i = 0; i < nwords; i++) begin
      logic [31:0] w;
      w = 32'd0;
      for (int b = 0; b < 4; b++) w += 32'(stream_q[4*i+b]) << (8*b);
      exp_q.push_back(w);
      sum ^= w;
    end
    chk({tag, "_we_count"}, 32'(we_count), 32'(nwords));
    n = (got_addr_q.size() < nwords) ? got_addr_q.size() : nwords;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_addr_q[i], 32'(4*i));
      chk($sformatf("%s_data%0d", tag, i), got_data_q[i], exp_q[i]);
    end
    chk({tag, "_checksum"},   checksum,        sum);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
    chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    chk({tag, "_ready_stall"}, 32'(ready_stall_ok), 32'd1);
    if (nwords > 0) begin
      chk({tag, "_addr_hold"},  mem_addr,  32'(4*(nwords-1)));
      chk({tag, "_wdata_hold"}, mem_wdata, exp_q[nwords-1]);
    end
  endtask

  task automatic run_load(input string tag, input int nwords, input int gmin, input int gmax);
    clear_capture();
    pulse_start(nwords);
    send_range(0, 4*nwords, gmin, gmax);
    wait_done(tag);
    repeat (2) tick();
    check_load(tag, nwords);
  endtask

  initial begin
    // Power-on reset.
    #2;
    check_reset_values("por");
    repeat (2) tick();
    release_reset();
    check_reset_values("idle");

    // Two words, continuous stream, then the same stream with stalls.
    stream_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h10, 8'h00};
    run_load("dir", 2, 0, 0);
    run_load("stall", 2, 3, 3);

    // Zero-length load.
    clear_capture();
    pulse_start(0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_err", 32'(err), 32'd0);
    chk("zero_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    byte_valid = 1'b1;
    chk("zero_byte_ready", 32'(byte_ready), 32'd0);
    repeat (3) tick();
    byte_valid = 1'b0;
    chk("zero_we_count", 32'(we_count), 32'd0);

    // Oversize load.
    clear_capture();
    pulse_start(1025);
    chk("big_err", 32'(err), 32'd1);
    chk("big_done", 32'(done), 32'd1);
    chk("big_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("big_busy", 32'(busy), 32'd0);
    byte_valid = 1'b1;
    chk("big_byte_ready", 32'(byte_ready), 32'd0);
    repeat (4) tick();
    byte_valid = 1'b0;
    chk("big_we_count", 32'(we_count), 32'd0);

    // Randomized loads of varying length and pacing.
    for (int r = 0; r < 4; r++) begin
      int nw;
      nw = $urandom_range(1, 12);
      random_stream(4*nw);
      run_load($sformatf("rnd%0d", r), nw, 0, 3);
    end

    // Full memory: last write must land at byte address 4092.
    random_stream(4*1024);
    run_load("full", 1024, 0, 0);

    // Reset after six bytes of a three-word load.
    random_stream(12);
    clear_capture();
    pulse_start(3);
    send_range(0, 6, 0, 0);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    chk("midrst_we_count", 32'(we_count), 32'd1);
    if (got_addr_q.size() > 0) begin
      chk("midrst_addr0", got_addr_q[0], 32'd0);
      chk("midrst_data0", got_data_q[0],
          32'(stream_q[0]) + (32'(stream_q[1]) << 8) + (32'(stream_q[2]) << 16) + (32'(stream_q[3]) << 24));
    end
    repeat (2) tick();
    release_reset();
    random_stream(4);
    run_load("postrst", 1, 0, 2);

    // start pulsed in the middle of COLLECT is ignored.
    random_stream(8);
    clear_capture();
    pulse_start(2);
    send_range(0, 2, 0, 0);
    pulse_start(5);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_ready", 32'(byte_ready), 32'd1);
    send_range(2, 8, 0, 1);
    wait_done("restart");
    repeat (2) tick();
    check_load("restart", 2);

    // Reload from DONE rewrites from word 0 and holds the core again.
    random_stream(4);
    clear_capture();
    pulse_start(1);
    chk("reload_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_checksum_clr", checksum, 32'd0);
    send_range(0, 4, 0, 0);
    wait_done("reload");
    repeat (2) tick();
    check_load("reload", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
